serial_receive: RTL and testbench

//  Asynchronous serial (8N1, LSB first, idle-high) receiver: the RX end of the

---
 rtl/serial_receive.sv | 124 ++++++++++++
 tb/tb_serial_receive.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_receive.sv
// 8N1 LSB-first serial receiver: samples the synchronised RX line on a divided
// strobe, reassembles one byte per frame and flags framing errors.
module serial_receive #(
  parameter int QTR_BITS = 2,
  parameter int BAUD     = 2604,
  parameter int HBAUD    = 1302
) (
  input  logic       CLK_100_I,
  input  logic       RSTN_I,
  input  logic       SERIAL_I,
  output logic [7:0] BYTE_O,
  output logic       RDY_O,
  output logic       FRAME_ERR_O,
  output logic       BUSY_O
);

  // Handshake: RDY_O is a one-cycle valid pulse with no ready back-pressure;
  // BYTE_O holds the last good byte until the next good frame overwrites it.

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [11:0] BAUD_L  = 12'(BAUD);
  localparam logic [11:0] HBAUD_L = 12'(HBAUD);

  state_t              state;
  logic [QTR_BITS-1:0] qtr_cnt;
  logic                strb;
  logic [1:0]          sync_q;
  logic                rx;
  logic [11:0]         baud_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift;

  assign strb   = &qtr_cnt;
  assign rx     = sync_q[1];
  assign BUSY_O = (state != S_IDLE);

  always_ff @(posedge CLK_100_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      qtr_cnt <= '0;
      sync_q  <= 2'b11;
    end else begin
      qtr_cnt <= qtr_cnt + 1'b1;
      sync_q  <= {sync_q[0], SERIAL_I};
    end
  end

  always_ff @(posedge CLK_100_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      BYTE_O      <= '0;
      RDY_O       <= 1'b0;
      FRAME_ERR_O <= 1'b0;
    end else begin
      RDY_O       <= 1'b0;
      FRAME_ERR_O <= 1'b0;
      if (strb) begin
        case (state)
          S_IDLE: begin
            if (!rx) begin
              state    <= S_START;
              baud_cnt <= '0;
            end
          end
          S_START: begin
            // Half-bit check rejects glitches shorter than half a start bit.
            if (baud_cnt == HBAUD_L) begin
              baud_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx ? S_IDLE : S_DATA;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (baud_cnt == BAUD_L) begin
              shift[bit_cnt] <= rx;
              baud_cnt       <= '0;
              if (bit_cnt == 3'd7) begin
                state <= S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          S_STOP: begin
            // Leaving mid-stop-bit lets an immediately following start bit be caught.
            if (baud_cnt == BAUD_L) begin
              baud_cnt <= '0;
              if (rx) begin
                BYTE_O <= shift;
                RDY_O  <= 1'b1;
                state  <= S_IDLE;
              end else begin
                FRAME_ERR_O <= 1'b1;
                state       <= S_BREAK;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          S_BREAK: begin
            if (rx) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_receive.sv
// Directed bench for serial_receive with a shortened bit period (16 strobes =
// 64 clocks) so that every frame scenario runs in a few thousand cycles.
module tb_serial_receive;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic [7:0] byte_o;
  logic       rdy;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int rdy_base;
  int err_base;
  logic [7:0] exp_q[$];

  serial_receive #(
    .QTR_BITS(2),
    .BAUD    (15),
    .HBAUD   (7)
  ) dut (
    .CLK_100_I  (clk),
    .RSTN_I     (rst_n),
    .SERIAL_I   (serial),
    .BYTE_O     (byte_o),
    .RDY_O      (rdy),
    .FRAME_ERR_O(frame_err),
    .BUSY_O     (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int clks);
    serial = v;
    idle_clks(clks);
  endtask

  task automatic send_byte(input logic [7:0] b, input int clks, input logic stop_val);
    drive_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) drive_bit(b[i], clks);
    drive_bit(stop_val, clks);
    serial = 1'b1;
  endtask

  // scoreboard: every RDY pulse must match the oldest expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy && frame_err) check("rdy_err_overlap", 32'(1), 32'(0));
      if (frame_err) err_cnt++;
      if (rdy) begin
        rdy_cnt++;
        if (exp_q.size() == 0) begin
          check("rdy_unexpected", 32'(byte_o), 32'hFFFF_FFFF);
        end else begin
          check("rdy_byte", 32'(byte_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic mark;
    rdy_base = rdy_cnt;
    err_base = err_cnt;
  endtask

  initial begin
    rst_n  = 1'b0;
    serial = 1'b1;
    idle_clks(10);
    check("reset_byte", 32'(byte_o), 32'(0));
    check("reset_rdy",  32'(rdy), 32'(0));
    check("reset_err",  32'(frame_err), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    idle_clks(20);

    // 1: single frame
    mark();
    exp_q.push_back(8'h55);
    send_byte(8'h55, BIT_CLKS, 1'b1);
    idle_clks(BIT_CLKS);
    check("t1_rdy_cnt", 32'(rdy_cnt - rdy_base), 32'(1));
    check("t1_byte", 32'(byte_o), 32'h55);
    check("t1_busy", 32'(busy), 32'(0));

    // 2: back-to-back frames
    mark();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    send_byte(8'h00, BIT_CLKS, 1'b1);
    send_byte(8'hFF, BIT_CLKS, 1'b1);
    send_byte(8'hA5, BIT_CLKS, 1'b1);
    idle_clks(BIT_CLKS);
    check("t2_rdy_cnt", 32'(rdy_cnt - rdy_base), 32'(3));
    check("t2_err_cnt", 32'(err_cnt - err_base), 32'(0));
    check("t2_byte", 32'(byte_o), 32'hA5);

    // 3: glitch shorter than half a bit
    mark();
    serial = 1'b0;
    idle_clks(20);
    check("t3_busy_during", 32'(busy), 32'(1));
    serial = 1'b1;
    idle_clks(2 * BIT_CLKS);
    check("t3_busy_after", 32'(busy), 32'(0));
    check("t3_rdy_cnt", 32'(rdy_cnt - rdy_base), 32'(0));
    check("t3_err_cnt", 32'(err_cnt - err_base), 32'(0));
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, BIT_CLKS, 1'b1);
    idle_clks(BIT_CLKS);
    check("t3_byte", 32'(byte_o), 32'h3C);

    // 4: framing error then break
    mark();
    send_byte(8'hA5, BIT_CLKS, 1'b0);
    serial = 1'b0;
    idle_clks(3 * BIT_CLKS);
    check("t4_busy_break", 32'(busy), 32'(1));
    serial = 1'b1;
    idle_clks(BIT_CLKS);
    check("t4_err_cnt", 32'(err_cnt - err_base), 32'(1));
    check("t4_rdy_cnt", 32'(rdy_cnt - rdy_base), 32'(0));
    check("t4_byte_kept", 32'(byte_o), 32'h3C);
    check("t4_busy_after", 32'(busy), 32'(0));
    mark();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, BIT_CLKS, 1'b1);
    idle_clks(BIT_CLKS);
    check("t4_rdy_cnt2", 32'(rdy_cnt - rdy_base), 32'(1));
    check("t4_err_cnt2", 32'(err_cnt - err_base), 32'(0));

    // 5: reset in the middle of data bit 4
    mark();
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS / 2);
    check("t5_busy_pre", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_byte", 32'(byte_o), 32'(0));
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_rdy",  32'(rdy), 32'(0));
    check("t5_rst_err",  32'(frame_err), 32'(0));
    idle_clks(10);
    serial = 1'b1;
    idle_clks(10);
    rst_n = 1'b1;
    idle_clks(BIT_CLKS);
    exp_q.push_back(8'h81);
    send_byte(8'h81, BIT_CLKS, 1'b1);
    idle_clks(BIT_CLKS);
    check("t5_rdy_cnt", 32'(rdy_cnt - rdy_base), 32'(1));
    check("t5_byte", 32'(byte_o), 32'h81);

    // 6: bit period skewed by about +/-2%
    mark();
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, BIT_CLKS - 1, 1'b1);
    idle_clks(BIT_CLKS);
    check("t6_byte_fast", 32'(byte_o), 32'h5A);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, BIT_CLKS + 1, 1'b1);
    idle_clks(BIT_CLKS);
    check("t6_byte_slow", 32'(byte_o), 32'hC3);
    check("t6_rdy_cnt", 32'(rdy_cnt - rdy_base), 32'(2));
    check("t6_err_cnt", 32'(err_cnt - err_base), 32'(0));

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
